up_core_param: RTL and testbench
================================

# up_core_param

Parametrised accumulator microprocessor core: the generalised successor of the team's fixed 4-bit two-phase CPU. It keeps the fetch/execute phase scheme and the 16-opcode ISA, and adds:
- configurable data width and I/O channel count;
- real carry/zero flags driven by an ALU;
- external program/data memory interfaces;
- an optional wait-state handshake on data memory.

It sits at the top of the processor datapath, between the program ROM, data RAM and board I/O.

## Interface
- DATA_W, 4, accumulator/operand/RAM data width; instruction word PW = 4 + DATA_W.
- N_IO, 1, number of input and output channels, 1..2^DATA_W.
- ADDR_W, derived (not overridable), = DATA_W + PW; program and RAM address width (12 at default).

- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- prog_addr  out  ADDR_W  program counter.
- prog_word  in  PW  program memory word at prog_addr, combinational read.
- ram_addr  out  ADDR_W  {oprnd, prog_word}.
- ram_wdata  out  DATA_W  = accu.
- ram_rdata  in  DATA_W  combinational read data.
- ram_cs, ram_we  out  1  chip select / write enable, execute phase only.
- ram_ready  in  1  present only with UP_WAIT_EN.
- in_bus  in  N_IO*DATA_W  input channels, channel k at [k*DATA_W +: DATA_W].
- out_bus  out  N_IO*DATA_W  registered output channels.
- out_strobe  out  N_IO  one-cycle pulse on the written channel.
- phase  out  1  0 = fetch, 1 = execute.
- instr  out  4  latched opcode.
- oprnd  out  DATA_W  latched operand.
- accu  out  DATA_W  accumulator.
- c_flag, z_flag  out  1  flags.

## Operation
- Reset values: prog_addr=0, phase=0, instr=0, oprnd=0, accu=0, c_flag=0, z_flag=0, out_bus=0, out_strobe=0.
- Fetch (phase 0):
  - latch instr=prog_word[PW-1:DATA_W] and oprnd=prog_word[DATA_W-1:0];
  - PC+1;
  - phase toggles to 1.
- Execute (phase 1): perform the instruction, then phase toggles to 0.
- Two-word instructions use the second word (prog_word at the current PC) as the low address bits. These are jumps, LD, ST, ADDM, CMPM, NANDM.
  - Address = {oprnd, prog_word}.
  - Taken jump: PC = address.
  - All other two-word cases: PC+1.
- One-word instructions leave PC unchanged in execute.
- Opcodes:
  - 0 JC, 1 JNC, 2 CMPI, 3 CMPM, 4 LIT, 5 IN, 6 LD, 7 ST;
  - 8 JZ, 9 JNZ, A ADDI, B ADDM, C JMP, D OUT, E NANDI, F NANDM.
- Operand X is oprnd for immediate forms and ram_rdata for memory forms.
- ADD: {C, A} = A + X; Z = (A_new == 0).
- CMP: computes A + ~X + 1, accu unchanged.
  - C = carry out, so C=1 iff A ≥ X unsigned.
  - Z = (A == X).
- NAND: A = ~(A & X); Z = (A_new == 0); C = 0.
- LIT / IN / LD load A; flags unchanged.
  - IN reads channel oprnd.
  - Channel index ≥ N_IO reads 0.
- ST: ram_cs = ram_we = 1 in execute; ram_wdata = accu.
- LD and the memory ALU ops: ram_cs=1, ram_we=0.
- OUT: out_bus channel oprnd ← accu; out_strobe bit oprnd = 1 for that execute edge only.
  - Channel index ≥ N_IO is a no-op with no strobe.
- PC wraps from 2^ADDR_W−1 to 0.

## Timing
- Every instruction takes 2 cycles (fetch + execute) without wait states.
- All state updates on the rising clock edge.
- ram_cs, ram_we and ram_addr are combinational from instr/oprnd/prog_word/phase, and valid only while phase=1.
- out_bus and out_strobe are registered: visible the cycle after the execute edge.
- Reset asserted in any phase overrides everything at the next edge, including a pending wait state.
- The flags register loads only on ADD, CMP and NAND execute edges.

## Configuration
- UP_WAIT_EN defined: ram_ready port exists.
  - In execute of any RAM-accessing instruction with ram_ready=0: phase, PC, accu, flags and outputs hold; ram_cs/ram_we stay asserted.
  - The instruction completes on the first edge with ram_ready=1.
  - Non-RAM instructions ignore ram_ready.
- UP_WAIT_EN not defined: no ram_ready port; all RAM accesses complete in one execute cycle.

## Structure
- Package up_pkg:
  - opcode enumeration (16 values);
  - phase typedef;
  - ALU op-select typedef (ADD, SUB, NAND, PASS);
  - helper constant for PW and ADDR_W derivation.
- Sub-module up_alu: combinational, DATA_W-parametrised; inputs A, X, op; outputs result, carry, zero.
- The sequencer, PC and register file stay in up_core_param.

## Test plan
- Reset → prog_addr=0x000, phase=0, accu=0, flags 0, out_bus=0; reset asserted mid-execute → all return to reset values next edge.
- LIT 9 then ADDI 8 → after 4 cycles accu=0x1, c_flag=1, z_flag=0; then NANDI F → accu=0xE, c_flag=0.
- accu=5, CMPI 5 → z=1, c=1, accu=5. Then JZ with oprnd=1, second word 0x23 → PC=0x123. JNZ in the same state → PC advances by 2.
- accu=0xA, ST oprnd=3, word 0xFF → one cycle with ram_addr=0x3FF, ram_we=1, ram_wdata=0xA; LD same address with ram_rdata=0xA → accu=0xA.
- N_IO=4, accu=0x7, OUT 2 → out_bus[11:8]=0x7, out_strobe=4'b0100 for one cycle. OUT 5 → no change, no strobe.
- UP_WAIT_EN, LD with ram_ready low 3 cycles → phase=1 and PC frozen for 3 cycles; accu loads on the 4th edge; total instruction 5 cycles.

Source files
------------

// File: rtl/up_pkg.sv
// Shared types for up_core_param: opcodes, phase, ALU op-select and width helpers.
// Pure declarations; no logic, no latency, no flow control.
package up_pkg;

   localparam int OPC_W = 4;

   typedef enum logic [3:0] {
      OP_JC    = 4'h0,
      OP_JNC   = 4'h1,
      OP_CMPI  = 4'h2,
      OP_CMPM  = 4'h3,
      OP_LIT   = 4'h4,
      OP_IN    = 4'h5,
      OP_LD    = 4'h6,
      OP_ST    = 4'h7,
      OP_JZ    = 4'h8,
      OP_JNZ   = 4'h9,
      OP_ADDI  = 4'hA,
      OP_ADDM  = 4'hB,
      OP_JMP   = 4'hC,
      OP_OUT   = 4'hD,
      OP_NANDI = 4'hE,
      OP_NANDM = 4'hF
   } opcode_t;

   typedef enum logic {
      PH_FETCH = 1'b0,
      PH_EXEC  = 1'b1
   } phase_t;

   typedef enum logic [1:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_NAND,
      ALU_PASS
   } alu_op_t;

   function automatic int pw_of(input int data_w);
      return OPC_W + data_w;
   endfunction

   function automatic int addr_w_of(input int data_w);
      return data_w + pw_of(data_w);
   endfunction

endpackage

// File: rtl/up_alu.sv
// Combinational ALU for up_core_param: add, subtract (compare), nand, pass-through.
// Zero latency, no flow control; zero flag reflects the result of the selected op.
module up_alu
   import up_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] x,
   input  alu_op_t           op,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         ALU_ADD:  {carry, result} = {1'b0, a} + {1'b0, x};
         // carry out of a + ~x + 1 is the "no borrow" bit: set iff a >= x
         ALU_SUB:  {carry, result} = {1'b0, a} + {1'b0, ~x} + {{DATA_W{1'b0}}, 1'b1};
         ALU_NAND: result = ~(a & x);
         default:  result = x;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/up_core_param.sv
// Two-phase accumulator CPU: fetch then execute, 2 cycles per instruction; optional
// UP_WAIT_EN adds ram_ready, which stalls the execute phase of RAM instructions while low.
module up_core_param
   import up_pkg::*;
#(
   parameter  int DATA_W = 4,
   parameter  int N_IO   = 1,
   localparam int PW     = pw_of(DATA_W),
   localparam int ADDR_W = addr_w_of(DATA_W)
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic [ADDR_W-1:0]        prog_addr,
   input  logic [PW-1:0]            prog_word,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [DATA_W-1:0]        ram_wdata,
   input  logic [DATA_W-1:0]        ram_rdata,
   output logic                     ram_cs,
   output logic                     ram_we,
`ifdef UP_WAIT_EN
   input  logic                     ram_ready,
`endif
   input  logic [N_IO*DATA_W-1:0]   in_bus,
   output logic [N_IO*DATA_W-1:0]   out_bus,
   output logic [N_IO-1:0]          out_strobe,
   output logic                     phase,
   output logic [3:0]               instr,
   output logic [DATA_W-1:0]        oprnd,
   output logic [DATA_W-1:0]        accu,
   output logic                     c_flag,
   output logic                     z_flag
);

   phase_t                  ph_q, ph_d;
   opcode_t                 op;
   logic [ADDR_W-1:0]       pc_d;
   logic [3:0]              instr_d;
   logic [DATA_W-1:0]       oprnd_d, accu_d;
   logic                    c_d, z_d;
   logic [N_IO*DATA_W-1:0]  out_d;
   logic [N_IO-1:0]         strobe_d;

   logic                    is_two, is_mem, taken, ld_acc, ld_flg, do_out, stall;
   alu_op_t                 alu_op;
   logic [DATA_W-1:0]       alu_x, alu_res, in_sel;
   logic                    alu_c, alu_z;

   assign op        = opcode_t'(instr);
   assign phase     = ph_q;
   assign ram_addr  = {oprnd, prog_word};
   assign ram_wdata = accu;
   assign ram_cs    = (ph_q == PH_EXEC) && is_mem;
   assign ram_we    = (ph_q == PH_EXEC) && (op == OP_ST);

`ifdef UP_WAIT_EN
   assign stall = (ph_q == PH_EXEC) && is_mem && !ram_ready;
`else
   assign stall = 1'b0;
`endif

   // Out-of-range channel numbers fall through to zero
   always_comb begin
      in_sel = '0;
      for (int k = 0; k < N_IO; k++) begin
         if (oprnd == DATA_W'(k)) in_sel = in_bus[k*DATA_W +: DATA_W];
      end
   end

   // Instruction decode
   always_comb begin
      is_two = 1'b0;
      is_mem = 1'b0;
      taken  = 1'b0;
      ld_acc = 1'b0;
      ld_flg = 1'b0;
      do_out = 1'b0;
      alu_op = ALU_PASS;
      alu_x  = oprnd;
      case (op)
         OP_JC:    begin is_two = 1'b1; taken = c_flag;  end
         OP_JNC:   begin is_two = 1'b1; taken = !c_flag; end
         OP_JZ:    begin is_two = 1'b1; taken = z_flag;  end
         OP_JNZ:   begin is_two = 1'b1; taken = !z_flag; end
         OP_JMP:   begin is_two = 1'b1; taken = 1'b1;    end
         OP_CMPI:  begin alu_op = ALU_SUB; ld_flg = 1'b1; end
         OP_CMPM:  begin is_two = 1'b1; is_mem = 1'b1; alu_x = ram_rdata; alu_op = ALU_SUB; ld_flg = 1'b1; end
         OP_LIT:   ld_acc = 1'b1;
         OP_IN:    begin alu_x = in_sel; ld_acc = 1'b1; end
         OP_LD:    begin is_two = 1'b1; is_mem = 1'b1; alu_x = ram_rdata; ld_acc = 1'b1; end
         OP_ST:    begin is_two = 1'b1; is_mem = 1'b1; end
         OP_ADDI:  begin alu_op = ALU_ADD; ld_acc = 1'b1; ld_flg = 1'b1; end
         OP_ADDM:  begin is_two = 1'b1; is_mem = 1'b1; alu_x = ram_rdata; alu_op = ALU_ADD; ld_acc = 1'b1; ld_flg = 1'b1; end
         OP_OUT:   do_out = 1'b1;
         OP_NANDI: begin alu_op = ALU_NAND; ld_acc = 1'b1; ld_flg = 1'b1; end
         OP_NANDM: begin is_two = 1'b1; is_mem = 1'b1; alu_x = ram_rdata; alu_op = ALU_NAND; ld_acc = 1'b1; ld_flg = 1'b1; end
         default:  ;
      endcase
   end

   up_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (accu),
      .x      (alu_x),
      .op     (alu_op),
      .result (alu_res),
      .carry  (alu_c),
      .zero   (alu_z)
   );

   // Next-state: a stalled execute keeps every register as is and drops the strobe
   always_comb begin
      ph_d     = ph_q;
      pc_d     = prog_addr;
      instr_d  = instr;
      oprnd_d  = oprnd;
      accu_d   = accu;
      c_d      = c_flag;
      z_d      = z_flag;
      out_d    = out_bus;
      strobe_d = '0;
      if (ph_q == PH_FETCH) begin
         instr_d = prog_word[PW-1:DATA_W];
         oprnd_d = prog_word[DATA_W-1:0];
         pc_d    = prog_addr + ADDR_W'(1);
         ph_d    = PH_EXEC;
      end else if (!stall) begin
         ph_d = PH_FETCH;
         if (is_two) pc_d = taken ? ram_addr : prog_addr + ADDR_W'(1);
         if (ld_acc) accu_d = alu_res;
         if (ld_flg) begin
            c_d = alu_c;
            z_d = alu_z;
         end
         if (do_out) begin
            for (int k = 0; k < N_IO; k++) begin
               if (oprnd == DATA_W'(k)) begin
                  out_d[k*DATA_W +: DATA_W] = accu;
                  strobe_d[k]               = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ph_q       <= PH_FETCH;
         prog_addr  <= '0;
         instr      <= '0;
         oprnd      <= '0;
         accu       <= '0;
         c_flag     <= 1'b0;
         z_flag     <= 1'b0;
         out_bus    <= '0;
         out_strobe <= '0;
      end else begin
         ph_q       <= ph_d;
         prog_addr  <= pc_d;
         instr      <= instr_d;
         oprnd      <= oprnd_d;
         accu       <= accu_d;
         c_flag     <= c_d;
         z_flag     <= z_d;
         out_bus    <= out_d;
         out_strobe <= strobe_d;
      end
   end

endmodule

// File: tb/tb_up_core_param.sv
// Bench for up_core_param (DATA_W=4, N_IO=4): a program table runs through a ROM model and
// a scoreboard compares architectural state after every instruction; wait states when UP_WAIT_EN.
module tb_up_core_param;

   localparam int DW = 4;
   localparam int NIO = 4;
   localparam int PW = 8;
   localparam int AW = 12;

   logic            clock = 1'b0;
   logic            reset;
   logic [AW-1:0]   prog_addr;
   logic [PW-1:0]   prog_word;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_wdata, ram_rdata;
   logic            ram_cs, ram_we;
`ifdef UP_WAIT_EN
   logic            ram_ready;
`endif
   logic [NIO*DW-1:0] in_bus;
   logic [NIO*DW-1:0] out_bus;
   logic [NIO-1:0]    out_strobe;
   logic              phase;
   logic [3:0]        instr;
   logic [DW-1:0]     oprnd, accu;
   logic              c_flag, z_flag;

   logic [PW-1:0] rom [4096];
   logic [DW-1:0] ram [4096];

   always #5 clock = ~clock;

   assign prog_word = rom[prog_addr];
   assign ram_rdata = ram[ram_addr];

   always @(posedge clock) begin
      if (ram_cs && ram_we) ram[ram_addr] <= ram_wdata;
   end

   up_core_param #(.DATA_W(DW), .N_IO(NIO)) dut (
      .clock      (clock),
      .reset      (reset),
      .prog_addr  (prog_addr),
      .prog_word  (prog_word),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .ram_cs     (ram_cs),
      .ram_we     (ram_we),
`ifdef UP_WAIT_EN
      .ram_ready  (ram_ready),
`endif
      .in_bus     (in_bus),
      .out_bus    (out_bus),
      .out_strobe (out_strobe),
      .phase      (phase),
      .instr      (instr),
      .oprnd      (oprnd),
      .accu       (accu),
      .c_flag     (c_flag),
      .z_flag     (z_flag)
   );

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  opd;
      logic [7:0]  w2;
      logic [11:0] pc;
      logic [3:0]  acc;
      logic        c;
      logic        z;
      logic [15:0] outb;
      logic [3:0]  stb;
   } vec_t;

   vec_t tbl [25];
   vec_t sb [$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic bit two_word(input logic [3:0] op);
      return op inside {4'h0, 4'h1, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC, 4'hF};
   endfunction

   task automatic chk_reset_state(input string tag);
      chk({tag, "_pc"},     32'(prog_addr), 32'h0);
      chk({tag, "_phase"},  32'(phase), 32'h0);
      chk({tag, "_instr"},  32'(instr), 32'h0);
      chk({tag, "_oprnd"},  32'(oprnd), 32'h0);
      chk({tag, "_accu"},   32'(accu), 32'h0);
      chk({tag, "_c"},      32'(c_flag), 32'h0);
      chk({tag, "_z"},      32'(z_flag), 32'h0);
      chk({tag, "_out"},    32'(out_bus), 32'h0);
      chk({tag, "_strobe"}, 32'(out_strobe), 32'h0);
   endtask

   initial begin
      vec_t       e;
      logic [11:0] a;
      logic       prev_ph;
      int         we_cnt;
      logic [11:0] we_addr;
      logic [3:0] we_dat;

      //          op    opd   w2     pc      acc   c     z     outb      stb
      tbl[0]  = '{4'h4, 4'h9, 8'h00, 12'h001, 4'h9, 1'b0, 1'b0, 16'h0000, 4'b0000};
      tbl[1]  = '{4'hA, 4'h8, 8'h00, 12'h002, 4'h1, 1'b1, 1'b0, 16'h0000, 4'b0000};
      tbl[2]  = '{4'hE, 4'hF, 8'h00, 12'h003, 4'hE, 1'b0, 1'b0, 16'h0000, 4'b0000};
      tbl[3]  = '{4'h4, 4'h5, 8'h00, 12'h004, 4'h5, 1'b0, 1'b0, 16'h0000, 4'b0000};
      tbl[4]  = '{4'h2, 4'h5, 8'h00, 12'h005, 4'h5, 1'b1, 1'b1, 16'h0000, 4'b0000};
      tbl[5]  = '{4'h8, 4'h1, 8'h23, 12'h123, 4'h5, 1'b1, 1'b1, 16'h0000, 4'b0000};
      tbl[6]  = '{4'h9, 4'h0, 8'h00, 12'h125, 4'h5, 1'b1, 1'b1, 16'h0000, 4'b0000};
      tbl[7]  = '{4'h4, 4'hA, 8'h00, 12'h126, 4'hA, 1'b1, 1'b1, 16'h0000, 4'b0000};
      tbl[8]  = '{4'h7, 4'h3, 8'hFF, 12'h128, 4'hA, 1'b1, 1'b1, 16'h0000, 4'b0000};
      tbl[9]  = '{4'h4, 4'h0, 8'h00, 12'h129, 4'h0, 1'b1, 1'b1, 16'h0000, 4'b0000};
      tbl[10] = '{4'h6, 4'h3, 8'hFF, 12'h12B, 4'hA, 1'b1, 1'b1, 16'h0000, 4'b0000};
      tbl[11] = '{4'h2, 4'hC, 8'h00, 12'h12C, 4'hA, 1'b0, 1'b0, 16'h0000, 4'b0000};
      tbl[12] = '{4'h0, 4'h0, 8'h50, 12'h12E, 4'hA, 1'b0, 1'b0, 16'h0000, 4'b0000};
      tbl[13] = '{4'h1, 4'h2, 8'h00, 12'h200, 4'hA, 1'b0, 1'b0, 16'h0000, 4'b0000};
      tbl[14] = '{4'h5, 4'h2, 8'h00, 12'h201, 4'hC, 1'b0, 1'b0, 16'h0000, 4'b0000};
      tbl[15] = '{4'hB, 4'h0, 8'h10, 12'h203, 4'h0, 1'b1, 1'b1, 16'h0000, 4'b0000};
      tbl[16] = '{4'h5, 4'h7, 8'h00, 12'h204, 4'h0, 1'b1, 1'b1, 16'h0000, 4'b0000};
      tbl[17] = '{4'h4, 4'h7, 8'h00, 12'h205, 4'h7, 1'b1, 1'b1, 16'h0000, 4'b0000};
      tbl[18] = '{4'hD, 4'h2, 8'h00, 12'h206, 4'h7, 1'b1, 1'b1, 16'h0700, 4'b0100};
      tbl[19] = '{4'hD, 4'h5, 8'h00, 12'h207, 4'h7, 1'b1, 1'b1, 16'h0700, 4'b0000};
      tbl[20] = '{4'h3, 4'h0, 8'h10, 12'h209, 4'h7, 1'b1, 1'b0, 16'h0700, 4'b0000};
      tbl[21] = '{4'hF, 4'h0, 8'h11, 12'h20B, 4'h8, 1'b0, 1'b0, 16'h0700, 4'b0000};
      tbl[22] = '{4'hC, 4'hF, 8'hFE, 12'hFFE, 4'h8, 1'b0, 1'b0, 16'h0700, 4'b0000};
      tbl[23] = '{4'h4, 4'h1, 8'h00, 12'hFFF, 4'h1, 1'b0, 1'b0, 16'h0700, 4'b0000};
      tbl[24] = '{4'h4, 4'h2, 8'h00, 12'h000, 4'h2, 1'b0, 1'b0, 16'h0700, 4'b0000};

      for (int i = 0; i < 4096; i++) begin
         rom[i] = 8'h00;
         ram[i] = 4'h0;
      end
      ram[12'h010] = 4'h4;
      ram[12'h011] = 4'h7;
      in_bus = 16'h9C63;
`ifdef UP_WAIT_EN
      ram_ready = 1'b1;
`endif

      // Lay the program out along the expected control flow and queue expectations
      a = 12'h000;
      for (int i = 0; i < 25; i++) begin
         rom[a] = {tbl[i].op, tbl[i].opd};
         if (two_word(tbl[i].op)) rom[a + 12'h001] = tbl[i].w2;
         a = tbl[i].pc;
         sb.push_back(tbl[i]);
      end

      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk_reset_state("reset");
      reset = 1'b0;

      prev_ph = 1'b0;
      we_cnt = 0;
      we_addr = '0;
      we_dat = '0;
      for (int cyc = 0; cyc < 400 && sb.size() > 0; cyc++) begin
         @(posedge clock);
         #1;
         if (phase === 1'b1 && ram_we === 1'b1) begin
            we_cnt++;
            we_addr = ram_addr;
            we_dat = ram_wdata;
         end
         if (prev_ph === 1'b1 && phase === 1'b0) begin
            e = sb.pop_front();
            chk($sformatf("pc_op%0h@%0h", e.op, e.pc),   32'(prog_addr), 32'(e.pc));
            chk($sformatf("accu_op%0h@%0h", e.op, e.pc), 32'(accu), 32'(e.acc));
            chk($sformatf("c_op%0h@%0h", e.op, e.pc),    32'(c_flag), 32'(e.c));
            chk($sformatf("z_op%0h@%0h", e.op, e.pc),    32'(z_flag), 32'(e.z));
            chk($sformatf("out_op%0h@%0h", e.op, e.pc),  32'(out_bus), 32'(e.outb));
            chk($sformatf("stb_op%0h@%0h", e.op, e.pc),  32'(out_strobe), 32'(e.stb));
         end
         prev_ph = phase;
      end
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("st_we_cycles", 32'(we_cnt), 32'd1);
      chk("st_addr", 32'(we_addr), 32'h3FF);
      chk("st_wdata", 32'(we_dat), 32'hA);

      // Reset while in execute
      for (int i = 0; i < 10 && phase !== 1'b1; i++) begin
         @(posedge clock);
         #1;
      end
      chk("mid_exec_phase", 32'(phase), 32'h1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk_reset_state("mid_reset");

`ifdef UP_WAIT_EN
      // LD 3:FF with ram_ready low for three execute cycles
      rom[12'h000] = 8'h63;
      rom[12'h001] = 8'hFF;
      ram_ready = 1'b0;
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("ws_fetch_phase", 32'(phase), 32'h1);
      chk("ws_fetch_instr", 32'(instr), 32'h6);
      chk("ws_fetch_oprnd", 32'(oprnd), 32'h3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ws_cs_%0d", i), 32'(ram_cs), 32'h1);
         @(posedge clock);
         #1;
         chk($sformatf("ws_phase_%0d", i), 32'(phase), 32'h1);
         chk($sformatf("ws_pc_%0d", i), 32'(prog_addr), 32'h001);
         chk($sformatf("ws_accu_%0d", i), 32'(accu), 32'h0);
      end
      ram_ready = 1'b1;
      @(posedge clock);
      #1;
      chk("ws_done_accu", 32'(accu), 32'hA);
      chk("ws_done_phase", 32'(phase), 32'h0);
      chk("ws_done_pc", 32'(prog_addr), 32'h002);
`else
      reset = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
